// File: rtl/div_freq_monitor.sv
// div_freq_monitor: measures edge rate and duty of five divided clocks over a fixed window and flags deviations
module div_freq_monitor #(
  parameter int WINDOW   = 720,
  parameter int COUNT_W  = 16,
  parameter int RATIO0   = 4,
  parameter int RATIO1   = 8,
  parameter int RATIO2   = 9,
  parameter int RATIO3   = 12,
  parameter int RATIO4   = 80,
  parameter int FREQ_TOL = 1,
  parameter int DUTY_TOL = 36,
  parameter int SETTLE   = 3
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         div_in,
  input  logic               start,
  input  logic               cont_en,
  input  logic [2:0]         ch_sel,
  output logic               busy,
  output logic               done,
  output logic [4:0]         freq_ok,
  output logic [4:0]         duty_ok,
  output logic [4:0]         pass,
  output logic [COUNT_W-1:0] edge_cnt,
  output logic [COUNT_W-1:0] high_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_SETL, S_MEAS, S_EVAL, S_DONE} state_t;
  localparam int RATIO [5] = '{RATIO0, RATIO1, RATIO2, RATIO3, RATIO4};
  localparam logic [COUNT_W:0] DUTY_T = (COUNT_W+1)'(WINDOW / 2);
  state_t state, next;
  logic [COUNT_W-1:0] cnt;
  logic [4:0] s1, s2, prev;
  logic [COUNT_W-1:0] ecnt [5];
  logic [COUNT_W-1:0] hcnt [5];
  logic [COUNT_W-1:0] elat [5];
  logic [COUNT_W-1:0] hlat [5];
  logic [COUNT_W:0] fdiff [5];
  logic [COUNT_W:0] ddiff [5];
  logic [4:0] f_pass, d_pass;
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:  next = start ? S_SETL : S_IDLE;
      S_SETL:  next = (cnt == COUNT_W'(SETTLE - 1)) ? S_MEAS : S_SETL;
      S_MEAS:  next = (cnt == COUNT_W'(WINDOW - 1)) ? S_EVAL : S_MEAS;
      S_EVAL:  next = S_DONE;
      S_DONE:  next = cont_en ? S_SETL : S_IDLE;
      default: next = S_IDLE;
    endcase
  end
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign pass = freq_ok & duty_ok;
  assign edge_cnt = (ch_sel < 3'd5) ? elat[ch_sel] : '0;
  assign high_cnt = (ch_sel < 3'd5) ? hlat[ch_sel] : '0;
  // unsigned |count - target| one bit wider than the counters so it cannot overflow
  always_comb begin
    for (int n = 0; n < 5; n++) begin
      fdiff[n] = ({1'b0, ecnt[n]} >= (COUNT_W+1)'(WINDOW / RATIO[n]))
               ? {1'b0, ecnt[n]} - (COUNT_W+1)'(WINDOW / RATIO[n])
               : (COUNT_W+1)'(WINDOW / RATIO[n]) - {1'b0, ecnt[n]};
      ddiff[n] = ({1'b0, hcnt[n]} >= DUTY_T) ? {1'b0, hcnt[n]} - DUTY_T : DUTY_T - {1'b0, hcnt[n]};
      f_pass[n] = fdiff[n] <= (COUNT_W+1)'(FREQ_TOL);
      d_pass[n] = ddiff[n] <= (COUNT_W+1)'(DUTY_TOL);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
    end else begin
      state <= next;
      cnt   <= (next != state || state == S_IDLE) ? '0 : cnt + 1'b1;
      s1    <= div_in;
      s2    <= s1;
      prev  <= s2;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq_ok <= '0;
      duty_ok <= '0;
      for (int n = 0; n < 5; n++) begin
        ecnt[n] <= '0;
        hcnt[n] <= '0;
        elat[n] <= '0;
        hlat[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 5; n++) begin
        if (state == S_SETL) begin
          ecnt[n] <= '0;
          hcnt[n] <= '0;
        end else if (state == S_MEAS) begin
          if (s2[n] && !prev[n] && !(&ecnt[n])) ecnt[n] <= ecnt[n] + 1'b1;
          if (s2[n] && !(&hcnt[n])) hcnt[n] <= hcnt[n] + 1'b1;
        end
        if (state == S_EVAL) begin
          elat[n] <= ecnt[n];
          hlat[n] <= hcnt[n];
        end
      end
      if (state == S_EVAL) begin
        freq_ok <= f_pass;
        duty_ok <= d_pass;
      end
    end
  end
endmodule
